// File: rtl/quant_pkg.sv
// Shared fixed-point constants and helpers for the requantizer / dequantizer pair.
package quant_pkg;

   // Default formats: narrow Q2.10 in 12 bits, wide Q4.12 in 16 bits.
   localparam int FXP_IN_WIDTH     = 12;
   localparam int FXP_IN_FRACTION  = 10;
   localparam int FXP_OUT_WIDTH    = 16;
   localparam int FXP_OUT_FRACTION = 12;

   // Exact widening: the caller sign-extends the narrow word to 64 bits.
   // The caller then keeps the low bits it needs. The shift aligns the binary points.
   function automatic logic signed [63:0] fxp_expand(input logic signed [63:0] narrow,
                                                     input int              shift);
      return narrow <<< shift;
   endfunction

   // True when the wide format holds every narrow value with no loss.
   // The wide format needs at least as many fraction bits and integer bits as the narrow one.
   function automatic bit fxp_legal(input int in_width, input int in_fraction,
                                    input int out_width, input int out_fraction);
      return (out_fraction >= in_fraction) &&
             (out_width - out_fraction >= in_width - in_fraction);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a look-ahead read port (dout shows the head entry).
// A push is allowed while full if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Storage write; data needs no reset because count gates every read.
   // NOTE: memories stay out of the reset branch so they map onto plain RAM/flops without reset muxes.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state is only ever assigned with <= so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dequant_expand.sv
// Receiver side of the requantizer: takes unstallable narrow samples, buffers them,
// widens them exactly, and delivers them on a valid/ready stream with a frame marker.
module dequant_expand
   import quant_pkg::*;
#(
   parameter int In_WIDTH     = FXP_IN_WIDTH,
   parameter int In_FRACTION  = FXP_IN_FRACTION,
   parameter int Out_WIDTH    = FXP_OUT_WIDTH,
   parameter int Out_FRACTION = FXP_OUT_FRACTION,
   parameter int DEPTH        = 4,
   parameter int FRAME_LEN    = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [In_WIDTH-1:0]        x,
   output logic [Out_WIDTH-1:0]       out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic                       overflow,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int LW     = $clog2(DEPTH+1);
   localparam int FDEPTH = DEPTH - 1;
   localparam int FCW    = $clog2(FDEPTH+1);
   localparam int FW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int SHIFT  = Out_FRACTION - In_FRACTION;

   // Parameter sanity, caught at elaboration.
   if (!fxp_legal(In_WIDTH, In_FRACTION, Out_WIDTH, Out_FRACTION)) begin : g_bad_format
      $error("dequant_expand: output format cannot hold the input format exactly");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("dequant_expand: DEPTH must be at least 2");
   end
   if (FRAME_LEN < 1) begin : g_bad_frame
      $error("dequant_expand: FRAME_LEN must be at least 1");
   end

   logic                 pop;
   logic                 accept;
   logic                 load;
   logic                 load_valid;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [In_WIDTH-1:0]  fifo_dout;
   logic [FCW-1:0]       unused_fifo_count;
   logic [In_WIDTH-1:0]  next_narrow;
   logic signed [63:0]   wide;
   logic [Out_WIDTH-1:0] out_d;
   logic                 unused_wide_hi;
   logic [FW-1:0]        frame_pos;
   logic [FW-1:0]        pos_next;
   logic [FW-1:0]        load_pos;

   // The output register is the first slot, so the block is full when it is valid and the FIFO is full.
   assign pop        = out_valid && out_ready;
   assign accept     = in_valid && (!(out_valid && fifo_full) || pop);
   assign load       = !out_valid || pop;
   assign fifo_pop   = load && !fifo_empty;
   assign fifo_push  = accept && !(load && fifo_empty);
   assign load_valid = !fifo_empty || accept;

   // When the FIFO is empty, the incoming sample goes straight to the output register.
   assign next_narrow    = fifo_empty ? x : fifo_dout;
   assign wide           = fxp_expand(64'(signed'(next_narrow)), SHIFT);
   assign out_d          = wide[Out_WIDTH-1:0];
   assign unused_wide_hi = ^wide[63:Out_WIDTH];

   // frame_pos is the frame position of the sample on out, or of the next sample if out is empty.
   assign pos_next = (frame_pos == FW'(FRAME_LEN-1)) ? '0 : frame_pos + 1'b1;
   assign load_pos = pop ? pos_next : frame_pos;

   sync_fifo #(
      .WIDTH (In_WIDTH),
      .DEPTH (FDEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (x),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (unused_fifo_count)
   );

   // Output register, frame marker and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_pos <= '0;
         overflow  <= 1'b0;
      end else begin
         if (pop) frame_pos <= pos_next;
         if (in_valid && !accept) overflow <= 1'b1;
         if (load) begin
            out_valid <= load_valid;
            out_last  <= load_valid && (load_pos == FW'(FRAME_LEN-1));
            if (load_valid) out <= out_d;
         end
      end
   end

   // Occupancy including the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_dequant_expand.sv
// Self-checking bench for dequant_expand: directed scenarios plus random traffic.
// A queue-based reference model checks the outputs.
module tb_dequant_expand;

   localparam int IW    = 12;
   localparam int IF    = 10;
   localparam int OW    = 16;
   localparam int OF    = 12;
   localparam int DEPTH = 4;
   localparam int FL    = 64;
   localparam int LW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [IW-1:0] x = '0;
   logic          out_ready = 1'b0;
   logic [OW-1:0] out;
   logic          out_valid;
   logic          out_last;
   logic          overflow;
   logic [LW-1:0] level;

   always #5 clk = ~clk;

   dequant_expand #(
      .In_WIDTH     (IW),
      .In_FRACTION  (IF),
      .Out_WIDTH    (OW),
      .Out_FRACTION (OF),
      .DEPTH        (DEPTH),
      .FRAME_LEN    (FL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x         (x),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .overflow  (overflow),
      .level     (level)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state: held samples in order (head is on out), pops since reset, and the sticky flag.
   logic [IW-1:0] m_q[$];
   int            m_pops = 0;
   bit            m_ovf = 1'b0;
   logic [OW-1:0] m_last_out = '0;
   int            max_level = 0;

   // Value-level expansion: the real value is unchanged, so the code scales by 2^(OF-IF).
   function automatic logic [OW-1:0] expand(input logic [IW-1:0] v);
      int s;
      s = $signed(v);
      s = s * (1 << (OF - IF));
      return s[OW-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic compare();
      chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("level", 32'(level), m_q.size());
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("out", 32'(out), 32'((m_q.size() > 0) ? expand(m_q[0]) : m_last_out));
      if (m_q.size() > 0)
         chk("out_last", 32'(out_last), 32'((m_pops % FL) == FL - 1));
      if (m_q.size() > max_level) max_level = m_q.size();
   endtask

   // One clock cycle: drive inputs, update the model at the edge, and compare at the falling edge.
   task automatic step(input bit iv, input logic [IW-1:0] xv, input bit rdy, input bit r = 1'b0);
      bit pop;
      bit acc;
      rst       = r;
      in_valid  = iv;
      x         = xv;
      out_ready = rdy;
      @(posedge clk);
      if (r) begin
         m_q.delete();
         m_pops     = 0;
         m_ovf      = 1'b0;
         m_last_out = '0;
      end else begin
         pop = (m_q.size() > 0) && rdy;
         acc = iv && ((m_q.size() < DEPTH) || pop);
         if (pop) begin
            m_last_out = expand(m_q.pop_front());
            m_pops++;
         end
         if (acc) m_q.push_back(xv);
         if (iv && !acc) m_ovf = 1'b1;
      end
      @(negedge clk);
      compare();
   endtask

   initial begin
      @(negedge clk);

      // Reset state.
      step(1'b0, '0, 1'b0, 1'b1);
      chk("rst_out", 32'(out), 32'h0);
      chk("rst_last", 32'(out_last), 32'h0);

      // Expansion of the boundary codes, each one cycle after its strobe.
      step(1'b1, 12'h7FF, 1'b1);  chk("exp_7ff", 32'(out), 32'h1FFC);
      step(1'b1, 12'h800, 1'b1);  chk("exp_800", 32'(out), 32'hE000);
      step(1'b1, 12'h001, 1'b1);  chk("exp_001", 32'(out), 32'h0004);
      step(1'b1, 12'hFFF, 1'b1);  chk("exp_fff", 32'(out), 32'hFFFC);
      step(1'b0, '0, 1'b1);

      // Overflow: five pushes into a stalled block of four.
      for (int i = 1; i <= 5; i++) step(1'b1, IW'(i), 1'b0);
      chk("ovf_level", 32'(level), 32'd4);
      chk("ovf_flag", 32'(overflow), 32'h1);
      chk("ovf_hold", 32'(out), 32'h0004);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      chk("ovf_drained", 32'(out_valid), 32'h0);
      chk("ovf_sticky", 32'(overflow), 32'h1);
      chk("ovf_last_seen", 32'(out), 32'h0010);

      // Full with a simultaneous push and pop.
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, IW'(12'h100 + i), 1'b0);
      step(1'b1, 12'h123, 1'b1);
      chk("full_pp_level", 32'(level), 32'd4);
      chk("full_pp_ovf", 32'(overflow), 32'h0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

      // Random traffic with random stalls spans several frames.
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 99) < 60, IW'($urandom), $urandom_range(0, 99) < 70);

      // Mid-stream reset: the block is made non-empty and overflowed, with a partial frame, and then reset.
      for (int i = 0; i < 6; i++) step(1'b1, IW'($urandom), 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      chk("pre_rst_ovf", 32'(overflow), 32'h1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("mid_rst_out", 32'(out), 32'h0);
      chk("mid_rst_last", 32'(out_last), 32'h0);
      step(1'b1, 12'h3A5, 1'b0);
      chk("post_rst_latency", 32'(out_valid), 32'h1);
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 99) < 50, IW'($urandom), $urandom_range(0, 99) < 60);

      // Back-to-back stream of one full frame after reset.
      step(1'b0, '0, 1'b0, 1'b1);
      max_level = 0;
      for (int i = 0; i < FL; i++) step(1'b1, IW'($urandom), 1'b1);
      chk("b2b_last_on_64th", 32'(out_last), 32'h1);
      step(1'b0, '0, 1'b1);
      chk("b2b_max_level", 32'(max_level), 32'd1);
      chk("b2b_empty", 32'(out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
